// File: rtl/cache_page_refill_if.sv
// Bus bundle between the cache controller, backing memory, cache SRAM/tag table and the page refill engine.
// The master modport is the refill engine; the slave modport is the surrounding environment.
interface cache_page_refill_if #(
  parameter int unsigned PAGE_BITS = 10,
  parameter int unsigned TAG_BITS  = 14,
  parameter int unsigned SLOT_BITS = 2
);
  logic                            refill_req;
  logic [TAG_BITS-1:0]             refill_tag;
  logic [SLOT_BITS-1:0]            refill_slot;
  logic [PAGE_BITS-1:0]            refill_offset;
  logic                            refill_busy;
  logic                            refill_done;
  logic                            crit_ready;
  logic                            mem_req;
  logic [TAG_BITS+PAGE_BITS-1:0]   mem_addr;
  logic                            mem_ack;
  logic [7:0]                      mem_rdata;
  logic                            sram_we;
  logic [SLOT_BITS+PAGE_BITS-1:0]  sram_addr;
  logic [7:0]                      sram_wdata;
  logic                            tag_we;
  logic [SLOT_BITS-1:0]            tag_slot;
  logic [TAG_BITS-1:0]             tag_value;
  logic                            tag_valid;

  modport master (
    input  refill_req, refill_tag, refill_slot, refill_offset, mem_ack, mem_rdata,
    output refill_busy, refill_done, crit_ready, mem_req, mem_addr,
           sram_we, sram_addr, sram_wdata, tag_we, tag_slot, tag_value, tag_valid
  );

  modport slave (
    output refill_req, refill_tag, refill_slot, refill_offset, mem_ack, mem_rdata,
    input  refill_busy, refill_done, crit_ready, mem_req, mem_addr,
           sram_we, sram_addr, sram_wdata, tag_we, tag_slot, tag_value, tag_valid
  );
endinterface

// File: rtl/cache_page_refill.sv
// Page refill engine for the cache miss path: invalidate victim tag, stream one page into SRAM, write tag valid.
// Optional macro CACHE_REFILL_CRITICAL_FIRST_EN: start at the critical byte offset and pulse crit_ready on it.
module cache_page_refill #(
  parameter int unsigned PAGE_BITS = 10,
  parameter int unsigned TAG_BITS  = 14,
  parameter int unsigned SLOT_BITS = 2
) (
  input logic                 fpgaClk,
  input logic                 reset,
  cache_page_refill_if.master bus
);
  localparam int unsigned ADDR_BITS = TAG_BITS + PAGE_BITS;
  localparam int unsigned SRAM_BITS = SLOT_BITS + PAGE_BITS;
  localparam logic [PAGE_BITS-1:0] LAST_BYTE = {PAGE_BITS{1'b1}};

  typedef enum logic [2:0] {IDLE, INVAL, FETCH, WRITE, TAG} state_t;

  state_t               state, stateD;
  logic [TAG_BITS-1:0]  tagQ, tagD;
  logic [SLOT_BITS-1:0] slotQ, slotD;
  logic [PAGE_BITS-1:0] offQ, offD;
  logic [PAGE_BITS-1:0] cntQ, cntD;

  logic                 busyD, doneD, critD, memReqD, sramWeD, tagWeD, tagValidD;
  logic [ADDR_BITS-1:0] memAddrD;
  logic [SRAM_BITS-1:0] sramAddrD;
  logic [7:0]           sramWdataD;
  logic [SLOT_BITS-1:0] tagSlotD;
  logic [TAG_BITS-1:0]  tagValueD;

`ifndef CACHE_REFILL_CRITICAL_FIRST_EN
  logic unusedOffset;
  assign unusedOffset = ^bus.refill_offset;
`endif

  // Next state, then registered outputs decoded from the state being entered.
  always_comb begin
    stateD     = state;
    tagD       = tagQ;
    slotD      = slotQ;
    offD       = offQ;
    cntD       = cntQ;
    busyD      = 1'b0;
    doneD      = 1'b0;
    critD      = 1'b0;
    memReqD    = 1'b0;
    memAddrD   = '0;
    sramWeD    = 1'b0;
    sramAddrD  = '0;
    sramWdataD = '0;
    tagWeD     = 1'b0;
    tagSlotD   = '0;
    tagValueD  = '0;
    tagValidD  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.refill_req) begin
          tagD  = bus.refill_tag;
          slotD = bus.refill_slot;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
          offD  = bus.refill_offset;
`else
          offD  = '0;
`endif
          cntD   = '0;
          stateD = INVAL;
        end
      end
      INVAL: stateD = FETCH;
      FETCH: if (bus.mem_ack) stateD = WRITE;
      WRITE: begin
        offD   = offQ + PAGE_BITS'(1);
        cntD   = cntQ + PAGE_BITS'(1);
        stateD = (cntQ == LAST_BYTE) ? TAG : FETCH;
      end
      TAG:     stateD = IDLE;
      default: stateD = IDLE;
    endcase

    busyD = (stateD != IDLE);

    // WRITE is only entered from FETCH on mem_ack, so mem_rdata is the byte to store.
    unique case (stateD)
      INVAL: begin
        tagWeD    = 1'b1;
        tagSlotD  = slotD;
        tagValueD = tagD;
      end
      FETCH: begin
        memReqD  = 1'b1;
        memAddrD = {tagD, offD};
      end
      WRITE: begin
        sramWeD    = 1'b1;
        sramAddrD  = {slotD, offD};
        sramWdataD = bus.mem_rdata;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
        critD      = (cntD == '0);
`endif
      end
      TAG: begin
        tagWeD    = 1'b1;
        tagSlotD  = slotD;
        tagValueD = tagD;
        tagValidD = 1'b1;
        doneD     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fpgaClk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      tagQ            <= '0;
      slotQ           <= '0;
      offQ            <= '0;
      cntQ            <= '0;
      bus.refill_busy <= 1'b0;
      bus.refill_done <= 1'b0;
      bus.crit_ready  <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.sram_we     <= 1'b0;
      bus.sram_addr   <= '0;
      bus.sram_wdata  <= '0;
      bus.tag_we      <= 1'b0;
      bus.tag_slot    <= '0;
      bus.tag_value   <= '0;
      bus.tag_valid   <= 1'b0;
    end else begin
      state           <= stateD;
      tagQ            <= tagD;
      slotQ           <= slotD;
      offQ            <= offD;
      cntQ            <= cntD;
      bus.refill_busy <= busyD;
      bus.refill_done <= doneD;
      bus.crit_ready  <= critD;
      bus.mem_req     <= memReqD;
      bus.mem_addr    <= memAddrD;
      bus.sram_we     <= sramWeD;
      bus.sram_addr   <= sramAddrD;
      bus.sram_wdata  <= sramWdataD;
      bus.tag_we      <= tagWeD;
      bus.tag_slot    <= tagSlotD;
      bus.tag_value   <= tagValueD;
      bus.tag_valid   <= tagValidD;
    end
  end
endmodule
